// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_tx
// Brief    : Paired L/R sample FIFOs feeding a left-justified codec DAC stream.
// Revision : 1.0
// ============================================================================

module audio_i2s_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int LW    = 4,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [15:0]   i_data,
    input  logic          i_pop,
    output logic [15:0]   o_data,
    output logic [LW-1:0] o_level
);
    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    // Storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;
endmodule

module audio_i2s_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int BCLK_HALF  = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_enable,
    input  logic [15:0]                        i_l_data,
    input  logic                               i_l_valid,
    output logic                               o_l_ready,
    input  logic [15:0]                        i_r_data,
    input  logic                               i_r_valid,
    output logic                               o_r_ready,
    output logic                               o_aud_bclk,
    output logic                               o_aud_daclrck,
    output logic                               o_aud_dacdat,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_l_level,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_r_level,
    output logic [15:0]                        o_underrun_count
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(BCLK_HALF);

    localparam logic [DW-1:0] c_DIV_LAST = DW'(BCLK_HALF - 1);
    localparam logic [LW-1:0] c_FULL     = LW'(FIFO_DEPTH);
    localparam logic [4:0]    c_BIT_LAST = 5'd31;

    logic [DW-1:0] r_div_cnt;
    logic          r_bclk;
    logic [4:0]    r_bit_cnt;
    logic          r_daclrck;
    logic          r_dacdat;
    logic [31:0]   r_frame;
    logic [15:0]   r_underrun;

    logic [LW-1:0] w_l_level;
    logic [LW-1:0] w_r_level;
    logic [15:0]   w_l_head;
    logic [15:0]   w_r_head;
    logic          w_l_ready;
    logic          w_r_ready;
    logic          w_l_push;
    logic          w_r_push;
    logic          w_div_wrap;
    logic          w_fall;
    logic          w_frame_start;
    logic          w_have_pair;
    logic          w_pop;
    logic          w_underrun;
    logic [4:0]    w_bit_next;
    logic [31:0]   w_frame_next;

    assign w_l_ready = !reset && (w_l_level != c_FULL);
    assign w_r_ready = !reset && (w_r_level != c_FULL);
    assign w_l_push  = i_l_valid && w_l_ready;
    assign w_r_push  = i_r_valid && w_r_ready;

    assign w_div_wrap    = (r_div_cnt == c_DIV_LAST);
    assign w_fall        = w_div_wrap && r_bclk;
    assign w_frame_start = w_fall && (r_bit_cnt == c_BIT_LAST);
    assign w_bit_next    = r_bit_cnt + 5'd1;

    // A pair is popped only when both sides hold data, so L/R never slip.
    assign w_have_pair = (w_l_level != '0) && (w_r_level != '0);
    assign w_pop       = w_frame_start && i_enable && w_have_pair;
    assign w_underrun  = w_frame_start && i_enable && !w_have_pair;

    always_comb begin
        w_frame_next = r_frame;
        if (w_frame_start) begin
            w_frame_next = w_pop ? {w_l_head, w_r_head} : 32'd0;
        end
    end

    audio_i2s_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LW    (LW),
        .AW    (AW)
    ) u_l_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_l_push),
        .i_data  (i_l_data),
        .i_pop   (w_pop),
        .o_data  (w_l_head),
        .o_level (w_l_level)
    );

    audio_i2s_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LW    (LW),
        .AW    (AW)
    ) u_r_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_r_push),
        .i_data  (i_r_data),
        .i_pop   (w_pop),
        .o_data  (w_r_head),
        .o_level (w_r_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    // Everything on the serial side advances only on BCLK fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= c_BIT_LAST;
            r_daclrck <= 1'b0;
            r_dacdat  <= 1'b0;
            r_frame   <= '0;
        end else if (w_fall) begin
            r_bit_cnt <= w_bit_next;
            r_daclrck <= ~w_bit_next[4];
            r_dacdat  <= w_frame_next[~w_bit_next];
            r_frame   <= w_frame_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_underrun <= '0;
        end else if (w_underrun && (r_underrun != 16'hFFFF)) begin
            r_underrun <= r_underrun + 16'd1;
        end
    end

    assign o_l_ready        = w_l_ready;
    assign o_r_ready        = w_r_ready;
    assign o_aud_bclk       = r_bclk;
    assign o_aud_daclrck    = r_daclrck;
    assign o_aud_dacdat     = r_dacdat;
    assign o_l_level        = w_l_level;
    assign o_r_level        = w_r_level;
    assign o_underrun_count = r_underrun;
endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_i2s_tx
// Brief    : Randomized scoreboard bench for audio_i2s_tx against a queue model.
// Revision : 1.0
// ============================================================================
module tb_audio_i2s_tx;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          i_enable;
    logic [15:0]   i_l_data;
    logic          i_l_valid;
    logic          o_l_ready;
    logic [15:0]   i_r_data;
    logic          i_r_valid;
    logic          o_r_ready;
    logic          o_aud_bclk;
    logic          o_aud_daclrck;
    logic          o_aud_dacdat;
    logic [LW-1:0] o_l_level;
    logic [LW-1:0] o_r_level;
    logic [15:0]   o_underrun_count;

    audio_i2s_tx #(.FIFO_DEPTH(DEPTH), .BCLK_HALF(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_enable         (i_enable),
        .i_l_data         (i_l_data),
        .i_l_valid        (i_l_valid),
        .o_l_ready        (o_l_ready),
        .i_r_data         (i_r_data),
        .i_r_valid        (i_r_valid),
        .o_r_ready        (o_r_ready),
        .o_aud_bclk       (o_aud_bclk),
        .o_aud_daclrck    (o_aud_daclrck),
        .o_aud_dacdat     (o_aud_dacdat),
        .o_l_level        (o_l_level),
        .o_r_level        (o_r_level),
        .o_underrun_count (o_underrun_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          frames_seen = 0;
    int unsigned k = 0;
    logic [15:0] lq[$];
    logic [15:0] rq[$];
    logic [31:0] sb[$];
    int          exp_under = 0;

    // Reference model: edges counted since reset release; a frame starts every
    // 1024 clk, the first one at the 32nd edge (first BCLK fall).
    initial begin
        logic lrdy, rrdy;
        logic [15:0] lh, rh;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                lq.delete(); rq.delete(); sb.delete();
                k = 0; exp_under = 0;
            end else begin
                k++;
                lrdy = (lq.size() != DEPTH);
                rrdy = (rq.size() != DEPTH);
                if (k % 1024 == 32) begin
                    if (i_enable && lq.size() > 0 && rq.size() > 0) begin
                        lh = lq.pop_front();
                        rh = rq.pop_front();
                        sb.push_back({lh, rh});
                    end else begin
                        sb.push_back(32'd0);
                        if (i_enable && exp_under < 65535) exp_under++;
                    end
                end
                if (i_l_valid && lrdy) lq.push_back(i_l_data);
                if (i_r_valid && rrdy) rq.push_back(i_r_data);
            end
        end
    end

    // Per-cycle status: readiness, levels, underruns and the clock waveforms.
    initial begin
        logic [40:0] e, a;
        int unsigned f, bc;
        forever begin
            @(negedge clk);
            f  = k / 32;
            bc = (31 + f) % 32;
            e = {!reset && (lq.size() != DEPTH), !reset && (rq.size() != DEPTH),
                 LW'(lq.size()), LW'(rq.size()), 16'(exp_under),
                 1'((k / 16) % 2), 1'(bc < 16), 13'd0};
            a = {o_l_ready, o_r_ready, o_l_level, o_r_level, o_underrun_count,
                 o_aud_bclk, o_aud_daclrck, 13'd0};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL status k=%0d rst=%0b got {lrdy,rrdy,ll,rl,und,bclk,lrck}=%h want=%h",
                         k, reset, a, e);
            end
        end
    end

    // Serial monitor: samples on BCLK rise like the codec, assembles 32 slots.
    initial begin
        logic        pb, pl, started;
        int          idx;
        logic [31:0] dat, lr, ex;
        pb = 0; pl = 0; started = 0; idx = 0; dat = 0; lr = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pb = 0; pl = 0; started = 0; idx = 0;
            end else begin
                if (o_aud_bclk && !pb) begin
                    if (!started && o_aud_daclrck && !pl) begin
                        started = 1; idx = 0;
                    end
                    if (started) begin
                        dat[31-idx] = o_aud_dacdat;
                        lr[31-idx]  = o_aud_daclrck;
                        idx++;
                        if (idx == 32) begin
                            started = 0; idx = 0;
                            frames_seen++;
                            total++;
                            if (sb.size() == 0) begin
                                bad++;
                                $display("FAIL frame unexpected got data=%h lr=%h want none", dat, lr);
                            end else begin
                                ex = sb.pop_front();
                                if ({dat, lr} !== {ex, 32'hFFFF0000}) begin
                                    bad++;
                                    $display("FAIL frame got data=%h lr=%h want data=%h lr=ffff0000",
                                             dat, lr, ex);
                                end
                            end
                        end
                    end
                    pl = o_aud_daclrck;
                end
                pb = o_aud_bclk;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        i_l_data = l; i_r_data = r; i_l_valid = 1; i_r_valid = 1;
        tick();
        i_l_valid = 0; i_r_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (3) tick();
        reset = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; i_enable = 0;
        i_l_data = 0; i_l_valid = 0; i_r_data = 0; i_r_valid = 0;
        repeat (5) tick();
        reset = 0;

        // Idle playback: zero frames and one underrun per frame.
        i_enable = 1;
        repeat (3 * 1024) tick();

        push_pair(16'hA5C3, 16'h1234);
        repeat (2 * 1024) tick();

        // Backpressure with playback paused, then drain paired.
        i_enable = 0;
        i_l_valid = 1;
        repeat (9) begin i_l_data = 16'($urandom); tick(); end
        i_l_valid = 0;
        repeat (10) tick();
        i_r_valid = 1;
        repeat (8) begin i_r_data = 16'($urandom); tick(); end
        i_r_valid = 0;
        i_enable = 1;
        repeat (9 * 1024) tick();

        // One-channel underrun keeps the left samples queued.
        do_reset();
        i_l_valid = 1;
        repeat (3) begin i_l_data = 16'($urandom); tick(); end
        i_l_valid = 0;
        repeat (2 * 1024) tick();
        i_r_data = 16'($urandom); i_r_valid = 1; tick(); i_r_valid = 0;
        repeat (2 * 1024) tick();

        // Push coinciding with the frame-start pop.
        do_reset();
        push_pair(16'($urandom), 16'($urandom));
        while (k % 1024 != 31) tick();
        push_pair(16'($urandom), 16'($urandom));
        repeat (2 * 1024 + 100) tick();

        // Reset in the middle of the right slot (bit 20).
        while (k % 1024 != 32 + 20 * 32 + 5) tick();
        do_reset();
        repeat (2 * 1024) tick();

        // Random traffic with occasional enable toggles.
        repeat (12 * 1024) begin
            if ($urandom_range(2999, 0) == 0) i_enable = ~i_enable;
            i_l_valid = ($urandom_range(799, 0) == 0);
            i_r_valid = ($urandom_range(799, 0) == 0);
            i_l_data  = 16'($urandom);
            i_r_data  = 16'($urandom);
            tick();
        end
        i_l_valid = 0; i_r_valid = 0;
        tick();

        total++;
        if (frames_seen < 25) begin
            bad++;
            $display("FAIL frame_count got %0d want >= 25", frames_seen);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
